// File: rtl/rv32i_alu_decoder_pkg.sv
// Shared RV32I decode constants: ALU op codes, instruction classes, operand selects and opcodes.
`timescale 1ns/1ps
package rv32i_alu_decoder_pkg;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SLL = 4'b0011,
        ALU_SUB = 4'b0100,
        ALU_SHR = 4'b0101,
        ALU_XOR = 4'b0111,
        ALU_SLT = 4'b1000
    } alu_op_e;

    typedef enum logic [2:0] {
        CLS_ALU    = 3'd0,
        CLS_LOAD   = 3'd1,
        CLS_STORE  = 3'd2,
        CLS_BRANCH = 3'd3,
        CLS_JAL    = 3'd4,
        CLS_JALR   = 3'd5,
        CLS_SYSTEM = 3'd6
    } class_e;

    typedef enum logic [1:0] {
        ASEL_RS1  = 2'b00,
        ASEL_PC   = 2'b01,
        ASEL_ZERO = 2'b10
    } a_sel_e;

    localparam logic BSEL_RS2 = 1'b0;
    localparam logic BSEL_IMM = 1'b1;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  alu_control;
        logic        alu_sgn;
        logic [1:0]  a_sel;
        logic        b_sel;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        reg_write;
        logic [2:0]  cls;
        logic [2:0]  funct3;
        logic        illegal;
    } decoded_t;

    function automatic logic [3:0] alu_from_funct3(input logic [2:0] funct3);
        logic [3:0] op;
        case (funct3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010,
            3'b011:  op = ALU_SLT;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SHR;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv32i_decode_comb.sv
// Purely combinational RV32I decode of one instruction word into the decoded_t bundle.
`timescale 1ns/1ps
module rv32i_decode_comb
    import rv32i_alu_decoder_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    output decoded_t    dec
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
    logic        writes;
    logic        illegal;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u  = {instr[31:12], 12'b0};
    assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_sh = {27'b0, instr[24:20]};

    always_comb begin
        dec             = '0;
        dec.pc          = pc;
        dec.rs1         = instr[19:15];
        dec.rs2         = instr[24:20];
        dec.rd          = instr[11:7];
        dec.funct3      = funct3;
        dec.alu_control = ALU_ADD;
        dec.a_sel       = ASEL_RS1;
        dec.b_sel       = BSEL_RS2;
        dec.cls         = CLS_ALU;
        writes          = 1'b0;
        illegal         = 1'b0;

        case (opcode)
            OPC_OP_IMM: begin
                writes          = 1'b1;
                dec.b_sel       = BSEL_IMM;
                dec.alu_control = alu_from_funct3(funct3);
                dec.alu_sgn     = (funct3 == 3'b010);
                dec.imm         = imm_i;
                if (funct3 == 3'b001) begin
                    dec.imm = imm_sh;
                    illegal = (funct7 != F7_BASE);
                end else if (funct3 == 3'b101) begin
                    dec.imm = imm_sh;
                    if (funct7 == F7_ALT)
                        dec.alu_sgn = 1'b1;
                    else if (funct7 != F7_BASE)
                        illegal = 1'b1;
                end
            end
            OPC_OP: begin
                writes          = 1'b1;
                dec.alu_control = alu_from_funct3(funct3);
                dec.alu_sgn     = (funct3 == 3'b010);
                // funct7 alternate form only encodes SUB and SRA
                if (funct7 == F7_ALT) begin
                    if (funct3 == 3'b000)
                        dec.alu_control = ALU_SUB;
                    else if (funct3 == 3'b101)
                        dec.alu_sgn = 1'b1;
                    else
                        illegal = 1'b1;
                end else if (funct7 != F7_BASE) begin
                    illegal = 1'b1;
                end
            end
            OPC_LUI: begin
                writes    = 1'b1;
                dec.a_sel = ASEL_ZERO;
                dec.b_sel = BSEL_IMM;
                dec.imm   = imm_u;
            end
            OPC_AUIPC: begin
                writes    = 1'b1;
                dec.a_sel = ASEL_PC;
                dec.b_sel = BSEL_IMM;
                dec.imm   = imm_u;
            end
            OPC_JAL: begin
                writes    = 1'b1;
                dec.cls   = CLS_JAL;
                dec.a_sel = ASEL_PC;
                dec.b_sel = BSEL_IMM;
                dec.imm   = imm_j;
            end
            OPC_JALR: begin
                writes    = 1'b1;
                dec.cls   = CLS_JALR;
                dec.b_sel = BSEL_IMM;
                dec.imm   = imm_i;
                illegal   = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                dec.cls = CLS_BRANCH;
                dec.imm = imm_b;
                case (funct3)
                    3'b000, 3'b001: dec.alu_control = ALU_SUB;
                    3'b100, 3'b101: begin
                        dec.alu_control = ALU_SLT;
                        dec.alu_sgn     = 1'b1;
                    end
                    3'b110, 3'b111: dec.alu_control = ALU_SLT;
                    default:        illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                writes    = 1'b1;
                dec.cls   = CLS_LOAD;
                dec.b_sel = BSEL_IMM;
                dec.imm   = imm_i;
                illegal   = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OPC_STORE: begin
                dec.cls   = CLS_STORE;
                dec.b_sel = BSEL_IMM;
                dec.imm   = imm_s;
                illegal   = (funct3 > 3'b010);
            end
            OPC_MISC_MEM, OPC_SYSTEM: begin
                dec.cls = CLS_SYSTEM;
            end
            default: illegal = 1'b1;
        endcase

        if (instr[1:0] != 2'b11)
            illegal = 1'b1;

        dec.illegal   = illegal;
        dec.reg_write = writes && (instr[11:7] != 5'd0) && !illegal;
    end

endmodule

// File: rtl/rv32i_alu_decoder.sv
// RV32I decoder front end: combinational decode into a one-cycle-latency skid buffer (or single stage).
`timescale 1ns/1ps
module rv32i_alu_decoder
    import rv32i_alu_decoder_pkg::*;
#(
    parameter bit SKID_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [3:0]  out_alu_control,
    output logic        out_alu_sgn,
    output logic [1:0]  out_a_sel,
    output logic        out_b_sel,
    output logic [31:0] out_imm,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [4:0]  out_rd,
    output logic        out_reg_write,
    output logic [2:0]  out_class,
    output logic [2:0]  out_funct3,
    output logic        out_illegal
);

    decoded_t    dec;
    decoded_t    head_p1;
    decoded_t    skid_p1;
    skid_state_e state_q, state_d;
    logic        rdy_q;
    logic        accept;
    logic        drain;

    rv32i_decode_comb u_decode (
        .instr (in_instr),
        .pc    (in_pc),
        .dec   (dec)
    );

    assign accept = in_valid && in_ready;
    assign drain  = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SKID_EMPTY;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            rdy_q   <= (state_d != SKID_FULL);
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = SKID_EMPTY;
        end else begin
            case (state_q)
                SKID_EMPTY: if (accept) state_d = SKID_ONE;
                SKID_ONE: begin
                    if (accept && !drain && SKID_EN)
                        state_d = SKID_FULL;
                    else if (!accept && drain)
                        state_d = SKID_EMPTY;
                end
                SKID_FULL:  if (drain) state_d = SKID_ONE;
                default:    state_d = SKID_EMPTY;
            endcase
        end
    end

    always_comb begin
        out_valid = (state_q != SKID_EMPTY);
        in_ready  = SKID_EN ? rdy_q : (!out_valid || out_ready);
    end

    // Stage 1: head presents the oldest entry; skid catches one more while the head stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_p1 <= '0;
            skid_p1 <= '0;
        end else if (!flush) begin
            case (state_q)
                SKID_EMPTY: if (accept) head_p1 <= dec;
                SKID_ONE: begin
                    if (accept && drain)
                        head_p1 <= dec;
                    else if (accept)
                        skid_p1 <= dec;
                end
                SKID_FULL:  if (drain) head_p1 <= skid_p1;
                default: ;
            endcase
        end
    end

    assign out_pc          = head_p1.pc;
    assign out_alu_control = head_p1.alu_control;
    assign out_alu_sgn     = head_p1.alu_sgn;
    assign out_a_sel       = head_p1.a_sel;
    assign out_b_sel       = head_p1.b_sel;
    assign out_imm         = head_p1.imm;
    assign out_rs1         = head_p1.rs1;
    assign out_rs2         = head_p1.rs2;
    assign out_rd          = head_p1.rd;
    assign out_reg_write   = head_p1.reg_write;
    assign out_class       = head_p1.cls;
    assign out_funct3      = head_p1.funct3;
    assign out_illegal     = head_p1.illegal;

endmodule

// File: tb/tb_rv32i_alu_decoder.sv
// Scoreboard bench for rv32i_alu_decoder: directed instruction vectors, backpressure, flush and reset.
`timescale 1ns/1ps
module tb_rv32i_alu_decoder;
    import rv32i_alu_decoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [3:0]  out_alu_control;
    logic        out_alu_sgn;
    logic [1:0]  out_a_sel;
    logic        out_b_sel;
    logic [31:0] out_imm;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic        out_reg_write;
    logic [2:0]  out_class;
    logic [2:0]  out_funct3;
    logic        out_illegal;

    always #5 clk = ~clk;

    rv32i_alu_decoder #(.SKID_EN(1'b1)) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_instr        (in_instr),
        .in_pc           (in_pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_alu_control (out_alu_control),
        .out_alu_sgn     (out_alu_sgn),
        .out_a_sel       (out_a_sel),
        .out_b_sel       (out_b_sel),
        .out_imm         (out_imm),
        .out_rs1         (out_rs1),
        .out_rs2         (out_rs2),
        .out_rd          (out_rd),
        .out_reg_write   (out_reg_write),
        .out_class       (out_class),
        .out_funct3      (out_funct3),
        .out_illegal     (out_illegal)
    );

    typedef struct {
        logic [31:0] instr;
        decoded_t    exp;
        decoded_t    mask;
    } sb_t;

    sb_t      sb[$];
    int       n_checks = 0;
    int       n_errors = 0;
    int       n_acc = 0;
    decoded_t hold;
    logic     hold_vld = 1'b0;

    function automatic decoded_t sample();
        decoded_t a;
        a.pc = out_pc; a.alu_control = out_alu_control; a.alu_sgn = out_alu_sgn;
        a.a_sel = out_a_sel; a.b_sel = out_b_sel; a.imm = out_imm;
        a.rs1 = out_rs1; a.rs2 = out_rs2; a.rd = out_rd; a.reg_write = out_reg_write;
        a.cls = out_class; a.funct3 = out_funct3; a.illegal = out_illegal;
        return a;
    endfunction

    function automatic decoded_t mk(input logic [31:0] pc, input logic [3:0] alu, input logic sgn,
                                    input logic [1:0] asel, input logic bsel, input logic [31:0] imm,
                                    input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                    input logic rw, input logic [2:0] cls, input logic [2:0] f3,
                                    input logic ill);
        decoded_t e;
        e.pc = pc; e.alu_control = alu; e.alu_sgn = sgn; e.a_sel = asel; e.b_sel = bsel;
        e.imm = imm; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.reg_write = rw;
        e.cls = cls; e.funct3 = f3; e.illegal = ill;
        return e;
    endfunction

    // pc, reg_write, funct3 and illegal are always compared; other fields only where defined
    function automatic decoded_t msk(input logic c_alu, input logic c_sel, input logic c_imm,
                                     input logic c_rs1, input logic c_rs2, input logic c_rd);
        decoded_t m;
        m = '1;
        if (!c_alu) begin m.alu_control = '0; m.alu_sgn = 1'b0; m.cls = '0; end
        if (!c_sel) begin m.a_sel = '0; m.b_sel = 1'b0; end
        if (!c_imm) m.imm = '0;
        if (!c_rs1) m.rs1 = '0;
        if (!c_rs2) m.rs2 = '0;
        if (!c_rd)  m.rd = '0;
        return m;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [31:0] instr, input decoded_t e, input decoded_t m);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = e.pc;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (ok) begin
            sb.push_back('{instr, e, m});
            n_acc++;
            @(posedge clk);
            #1;
        end else begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: instr %h in_ready %b expected 1", instr, in_ready);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        check("drain_remaining", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every output transfer and checks stall stability
    always @(negedge clk) begin
        decoded_t cur;
        sb_t      e;
        if (rst) begin
            hold_vld = 1'b0;
        end else begin
            cur = sample();
            if (hold_vld && out_valid) begin
                n_checks++;
                if (cur !== hold) begin
                    n_errors++;
                    $display("FAIL stall_stable: got %h expected %h", cur, hold);
                end
            end
            hold_vld = out_valid && !out_ready;
            hold     = cur;
            if (out_valid && out_ready && !flush) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_output: got pc %h expected no output", out_pc);
                end else begin
                    e = sb.pop_front();
                    if (((cur ^ e.exp) & e.mask) != '0) begin
                        n_errors++;
                        $display("FAIL decode %h: got %h expected %h mask %h",
                                 e.instr, cur, e.exp, e.mask);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_pc", out_pc, 0);
        check("rst_out_imm", out_imm, 0);
        check("rst_out_alu", out_alu_control, 0);
        check("rst_out_reg_write", out_reg_write, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;

        send(32'h002081B3, mk(32'h1000, 4'b0010, 0, 2'b00, 0, 32'h0, 1, 2, 3, 1, 3'd0, 3'b000, 0), msk(1,1,0,1,1,1));
        send(32'h40335293, mk(32'h1004, 4'b0101, 1, 2'b00, 1, 32'h3, 6, 0, 5, 1, 3'd0, 3'b101, 0), msk(1,1,1,1,0,1));
        send(32'h0020E463, mk(32'h1008, 4'b1000, 0, 2'b00, 0, 32'h8, 1, 2, 0, 0, 3'd3, 3'b110, 0), msk(1,1,1,1,1,0));
        send(32'hFFFFFFFF, mk(32'h100C, 4'b0000, 0, 2'b00, 0, 32'h0, 0, 0, 0, 0, 3'd0, 3'b111, 1), msk(0,0,0,0,0,0));
        send(32'h00000033, mk(32'h1010, 4'b0010, 0, 2'b00, 0, 32'h0, 0, 0, 0, 0, 3'd0, 3'b000, 0), msk(1,1,0,1,1,1));
        send(32'hFFC12283, mk(32'h1014, 4'b0010, 0, 2'b00, 1, 32'hFFFFFFFC, 2, 0, 5, 1, 3'd1, 3'b010, 0), msk(1,1,1,1,0,1));
        send(32'h00612423, mk(32'h1018, 4'b0010, 0, 2'b00, 1, 32'h8, 2, 6, 0, 0, 3'd2, 3'b010, 0), msk(1,1,1,1,1,0));
        send(32'hFF9FF0EF, mk(32'h101C, 4'b0010, 0, 2'b01, 1, 32'hFFFFFFF8, 0, 0, 1, 1, 3'd4, 3'b111, 0), msk(1,1,1,0,0,1));
        send(32'h123453B7, mk(32'h1020, 4'b0010, 0, 2'b10, 1, 32'h12345000, 0, 0, 7, 1, 3'd0, 3'b101, 0), msk(1,1,1,0,0,1));
        send(32'h00001517, mk(32'h1024, 4'b0010, 0, 2'b01, 1, 32'h00001000, 0, 0, 10, 1, 3'd0, 3'b001, 0), msk(1,1,1,0,0,1));
        send(32'h00008067, mk(32'h1028, 4'b0010, 0, 2'b00, 1, 32'h0, 1, 0, 0, 0, 3'd5, 3'b000, 0), msk(1,1,1,1,0,1));
        send(32'h00009067, mk(32'h102C, 4'b0000, 0, 2'b00, 0, 32'h0, 0, 0, 0, 0, 3'd0, 3'b001, 1), msk(0,0,0,0,0,0));
        send(32'h40628233, mk(32'h1030, 4'b0100, 0, 2'b00, 0, 32'h0, 5, 6, 4, 1, 3'd0, 3'b000, 0), msk(1,1,0,1,1,1));
        send(32'h4062E233, mk(32'h1034, 4'b0000, 0, 2'b00, 0, 32'h0, 0, 0, 0, 0, 3'd0, 3'b110, 1), msk(0,0,0,0,0,0));
        send(32'hFE20CEE3, mk(32'h1038, 4'b1000, 1, 2'b00, 0, 32'hFFFFFFFC, 1, 2, 0, 0, 3'd3, 3'b100, 0), msk(1,1,1,1,1,0));
        send(32'h00000063, mk(32'h103C, 4'b0100, 0, 2'b00, 0, 32'h0, 0, 0, 0, 0, 3'd3, 3'b000, 0), msk(1,1,1,1,1,0));
        send(32'h00000073, mk(32'h1040, 4'b0010, 0, 2'b00, 0, 32'h0, 0, 0, 0, 0, 3'd6, 3'b000, 0), msk(1,0,0,0,0,0));
        send(32'h0000000F, mk(32'h1044, 4'b0010, 0, 2'b00, 0, 32'h0, 0, 0, 0, 0, 3'd6, 3'b000, 0), msk(1,0,0,0,0,0));
        send(32'hFFF12093, mk(32'h1048, 4'b1000, 1, 2'b00, 1, 32'hFFFFFFFF, 2, 0, 1, 1, 3'd0, 3'b010, 0), msk(1,1,1,1,0,1));
        send(32'h40009093, mk(32'h104C, 4'b0000, 0, 2'b00, 0, 32'h0, 0, 0, 0, 0, 3'd0, 3'b001, 1), msk(0,0,0,0,0,0));
        send(32'h00003003, mk(32'h1050, 4'b0000, 0, 2'b00, 0, 32'h0, 0, 0, 0, 0, 3'd0, 3'b011, 1), msk(0,0,0,0,0,0));
        send(32'h00002063, mk(32'h1054, 4'b0000, 0, 2'b00, 0, 32'h0, 0, 0, 0, 0, 3'd0, 3'b010, 1), msk(0,0,0,0,0,0));
        send(32'h00000000, mk(32'h1058, 4'b0000, 0, 2'b00, 0, 32'h0, 0, 0, 0, 0, 3'd0, 3'b000, 1), msk(0,0,0,0,0,0));
        wait_drain();

        // Backpressure: three instructions offered while execute stalls
        out_ready = 1'b0;
        begin
            int acc0;
            acc0 = n_acc;
            fork
                begin
                    send(32'h40628233, mk(32'h2000, 4'b0100, 0, 2'b00, 0, 32'h0, 5, 6, 4, 1, 3'd0, 3'b000, 0), msk(1,1,0,1,1,1));
                    send(32'hFFC12283, mk(32'h2004, 4'b0010, 0, 2'b00, 1, 32'hFFFFFFFC, 2, 0, 5, 1, 3'd1, 3'b010, 0), msk(1,1,1,1,0,1));
                    send(32'hFF9FF0EF, mk(32'h2008, 4'b0010, 0, 2'b01, 1, 32'hFFFFFFF8, 0, 0, 1, 1, 3'd4, 3'b111, 0), msk(1,1,1,0,0,1));
                end
                begin
                    repeat (4) @(negedge clk);
                    check("bp_accepted", n_acc - acc0, 2);
                    check("bp_in_ready", in_ready, 0);
                    check("bp_out_valid", out_valid, 1);
                    @(posedge clk);
                    #1;
                    out_ready = 1'b1;
                end
            join
        end
        wait_drain();

        // Flush in ONE with a simultaneous offer, then flush in FULL
        for (int n = 1; n <= 2; n++) begin
            out_ready = 1'b0;
            send(32'h002081B3, mk(32'h3000, 4'b0010, 0, 2'b00, 0, 32'h0, 1, 2, 3, 1, 3'd0, 3'b000, 0), msk(1,1,0,1,1,1));
            if (n == 2)
                send(32'h40628233, mk(32'h3004, 4'b0100, 0, 2'b00, 0, 32'h0, 5, 6, 4, 1, 3'd0, 3'b000, 0), msk(1,1,0,1,1,1));
            in_valid = 1'b1;
            in_instr = 32'h123453B7;
            in_pc    = 32'h3008;
            flush    = 1'b1;
            @(posedge clk);
            #1;
            flush    = 1'b0;
            in_valid = 1'b0;
            sb.delete();
            @(negedge clk);
            check("flush_out_valid", out_valid, 0);
            check("flush_in_ready", in_ready, 1);
            @(posedge clk);
            #1;
            out_ready = 1'b1;
            repeat (3) @(negedge clk);
            check("flush_no_emit", out_valid, 0);
            @(posedge clk);
            #1;
            send(32'h40335293, mk(32'h3010, 4'b0101, 1, 2'b00, 1, 32'h3, 6, 0, 5, 1, 3'd0, 3'b101, 0), msk(1,1,1,1,0,1));
            wait_drain();
        end

        // Asynchronous reset with two entries held
        out_ready = 1'b0;
        send(32'h0020E463, mk(32'h4000, 4'b1000, 0, 2'b00, 0, 32'h8, 1, 2, 0, 0, 3'd3, 3'b110, 0), msk(1,1,1,1,1,0));
        send(32'hFFC12283, mk(32'h4004, 4'b0010, 0, 2'b00, 1, 32'hFFFFFFFC, 2, 0, 5, 1, 3'd1, 3'b010, 0), msk(1,1,1,1,0,1));
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_in_ready", in_ready, 1);
        check("arst_out_pc", out_pc, 0);
        check("arst_out_imm", out_imm, 0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("arst_no_emit", out_valid, 0);
        @(posedge clk);
        #1;
        send(32'hFF9FF0EF, mk(32'h4010, 4'b0010, 0, 2'b01, 1, 32'hFFFFFFF8, 0, 0, 1, 1, 3'd4, 3'b111, 0), msk(1,1,1,0,0,1));
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rv32i_alu_decoder.md
RV32I_ALU_DECODER -- requirements
Module: rv32i_alu_decoder

Interface
REQ-001 SHALL have parameter SKID_EN, default 1: 1 = two-entry skid buffer with registered in_ready; 0 = single register stage.
REQ-002 SHALL have ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  discard all held entries
- in_valid  in  1  fetch-side instruction valid
- in_ready  out  1  decoder can accept
- in_instr  in  32  RV32I instruction word
- in_pc  in  32  instruction PC
- out_valid  out  1  decoded entry valid
- out_ready  in  1  execute stage accepts
- out_pc  out  32  passed-through PC
- out_alu_control  out  4  ALU op code
- out_alu_sgn  out  1  signed select for SRA/SLT
- out_a_sel  out  2  operand A: 00 rs1, 01 pc, 10 zero
- out_b_sel  out  1  operand B: 0 rs2, 1 imm
- out_imm  out  32  sign-extended immediate
- out_rs1 / out_rs2 / out_rd  out  5 each  register indices
- out_reg_write  out  1  writeback enable
- out_class  out  3  0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 JAL, 5 JALR, 6 SYSTEM
- out_funct3  out  3  raw funct3 for branch/memory units
- out_illegal  out  1  instruction not legal RV32I

Function
REQ-003 SHALL produce these ALU codes: AND 0000, OR 0001, ADD 0010, SLL 0011, SUB 0100, SRL/SRA 0101, XOR 0111, SLT/SLTU 1000.
REQ-004 SHALL set alu_sgn=1 only for SRA/SRAI, SLT/SLTI, BLT/BGE; 0 otherwise.
REQ-005 Branches: BEQ/BNE -> SUB; BLT/BGE -> 1000 sgn 1; BLTU/BGEU -> 1000 sgn 0; a_sel rs1, b_sel rs2.
REQ-006 LOAD, STORE, JALR -> ADD, a_sel rs1, b_sel imm; AUIPC and JAL -> ADD, a_sel pc, b_sel imm; LUI -> ADD, a_sel zero, b_sel imm.
REQ-007 Immediates SHALL be I/S/B/U/J formatted per RV32I and sign-extended from bit 31; shift-immediate imm = zero-extended shamt.
REQ-008 out_reg_write SHALL be 1 only for ALU, LOAD, JAL, JALR, LUI, AUIPC with rd != 0 and not illegal.
REQ-009 out_illegal SHALL be 1 for: unknown opcode; shift-imm funct7 not 0000000 (0100000 allowed for SRAI); OP funct7 not 0000000, or 0100000 on anything other than ADD->SUB or SRL->SRA; branch funct3 010/011; load funct3 011/110/111; store funct3 > 010; JALR funct3 != 000; low two bits != 11.
REQ-010 FENCE and SYSTEM opcodes SHALL decode as class SYSTEM, ADD, reg_write 0, illegal 0.
REQ-011 Latency SHALL be one cycle: an instruction accepted at edge N SHALL appear at outputs after edge N.
REQ-012 Transfer occurs when valid and ready are both high at a rising edge; out_* SHALL remain stable while out_valid=1 and out_ready=0.
REQ-013 SKID_EN=1: states EMPTY, ONE, FULL; EMPTY->ONE on accept; ONE->FULL on accept with no drain; FULL->ONE on drain; ONE->EMPTY on drain with no accept; in_ready = (state != FULL), registered.
REQ-014 SKID_EN=0: in_ready = !out_valid || out_ready.
REQ-015 Order SHALL be preserved; simultaneous accept and drain in ONE SHALL stay in ONE with the new entry presented.
REQ-016 flush SHALL force EMPTY on the next edge and SHALL override a simultaneous accept; in_ready SHALL be 1 the cycle after flush.

Reset
REQ-017 rst SHALL asynchronously force state EMPTY, out_valid 0, in_ready 1 (SKID_EN=1), and all data outputs 0.
REQ-018 Entries held when rst asserts SHALL be discarded; no transfer SHALL occur while rst is high.

Structure
REQ-019 ALU codes, out_class values, a_sel encodings and RV32I opcode constants SHALL live in a shared package, also used by the ALU.
REQ-020 Decode SHALL be a combinational sub-module rv32i_decode_comb; the skid buffer and FSM SHALL be in the top module.

Verification
REQ-021 0x002081B3 (add x3,x1,x2) -> alu 0010, sgn 0, a_sel 00, b_sel 0, rd 3, reg_write 1, class 0.
REQ-022 0x40335293 (srai x5,x6,3) -> alu 0101, sgn 1, b_sel 1, imm 0x00000003, rd 5, illegal 0.
REQ-023 0x0020E463 (bltu x1,x2,+8) -> alu 1000, sgn 0, imm 0x00000008, class 3, reg_write 0.
REQ-024 0xFFFFFFFF -> illegal 1, reg_write 0; 0x00000033 (add x0) -> reg_write 0.
REQ-025 out_ready low for 3 cycles with in_valid high carrying 3 instructions -> exactly 2 accepted, in_ready 0, all 3 emerge in order after out_ready rises.
REQ-026 flush in FULL, or rst asserted mid-stream -> out_valid 0 after the flush edge (immediately for rst), no held entry emitted, next accepted instruction decodes normally.
